// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-granular round-robin arbiter sharing one fifo
// write port among NUM_REQ producers, with fifo backpressure.
//
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   req_valid_in/last_in      per-requester beat valid / last beat
//   req_data_in               requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_out             beat accepted on valid & ready
//   fifo_full_in              fifo full flag
//   fifo_valid_out/data_out   fifo write strobe / write data
//   grant_out, busy_out       current owner, transfer in progress
//   pkt_count_out             completed packets (wraps)
//   overrun_err_out           sticky: packet exceeded MAX_PKT_BEATS
module fifo_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_PKT_BEATS = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0]            req_last_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic                          fifo_full_in,
  output logic                          fifo_valid_out,
  output logic [DATA_WIDTH-1:0]         fifo_data_out,
  output logic [$clog2(NUM_REQ)-1:0]    grant_out,
  output logic                          busy_out,
  output logic [15:0]                   pkt_count_out,
  output logic                          overrun_err_out
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   win, cand;
  logic [BW-1:0]   beat_q, beat_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic            ovr_q, ovr_d;
  logic            busy, acc;

  // Search from rr_q+1 upward; descending loop so the
  // nearest valid requester is written last and wins.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid_in[cand]) win = cand;
    end
  end

  always_comb begin
    busy          = (state_q == XFER);
    req_ready_out = '0;
    if (busy && !fifo_full_in)
      req_ready_out[grant_q] = 1'b1;
    acc = busy && !fifo_full_in
        && req_valid_in[grant_q];
  end

  always_comb begin
    fifo_data_out = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q == GW'(i))
        fifo_data_out =
          req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    ovr_d     = ovr_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (|req_valid_in) begin
          grant_d = win;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      (state_q == XFER): begin
        if (acc) begin
          beat_d = beat_q + BW'(1);
          if (req_last_in[grant_q]) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            rr_d      = grant_q;
            state_d   = IDLE;
          end else if (beat_q ==
                       BW'(MAX_PKT_BEATS - 1)) begin
            // Runaway packet: release the port
            // without counting it as completed.
            ovr_d   = 1'b1;
            rr_d    = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= GW'(NUM_REQ - 1);
      beat_q    <= '0;
      pkt_cnt_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign fifo_valid_out  = acc;
  assign grant_out       = grant_q;
  assign busy_out        = busy;
  assign pkt_count_out   = pkt_cnt_q;
  assign overrun_err_out = ovr_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table, directed corner sequences
// and randomized traffic against a packet-level reference model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [N-1:0]    req_valid_in;
  logic [N-1:0]    req_last_in;
  logic [N*DW-1:0] req_data_in;
  logic [N-1:0]    req_ready_out;
  logic            fifo_full_in;
  logic            fifo_valid_out;
  logic [DW-1:0]   fifo_data_out;
  logic [1:0]      grant_out;
  logic            busy_out;
  logic [15:0]     pkt_count_out;
  logic            overrun_err_out;

  fifo_write_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .MAX_PKT_BEATS(MB)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in),
    .req_last_in(req_last_in),
    .req_data_in(req_data_in),
    .req_ready_out(req_ready_out),
    .fifo_full_in(fifo_full_in),
    .fifo_valid_out(fifo_valid_out),
    .fifo_data_out(fifo_data_out),
    .grant_out(grant_out),
    .busy_out(busy_out),
    .pkt_count_out(pkt_count_out),
    .overrun_err_out(overrun_err_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t mem [N][64];
  int    hd [N];
  int    tl [N];
  bit    en [N];
  bit    vld [N];

  bit    m_busy;
  int    m_owner;
  int    m_ptr;
  int    m_beats;
  int    m_pkt;
  bit    m_ovr;
  int    wr_cnt [N];
  int    order [$];

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic          f;
    logic [DW-1:0] d;
    logic [N-1:0]  er;
    logic          ev;
    logic          eb;
    int            eg;
    int            ep;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(int i, logic [DW-1:0] d, logic l);
    if (hd[i] == tl[i]) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    mem[i][tl[i]] = '{d, l};
    tl[i]++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      vld[i] = en[i] && (hd[i] < tl[i]);
      req_valid_in[i] = vld[i];
      req_last_in[i] = (hd[i] < tl[i]) ?
                       mem[i][hd[i]].l : 1'b0;
      req_data_in[i*DW +: DW] = (hd[i] < tl[i]) ?
                                mem[i][hd[i]].d : '0;
    end
  endtask

  // One clock: present inputs, compare against the model,
  // advance the model by what the arbiter must do at the edge.
  task automatic cyc();
    logic [N-1:0] er;
    bit ev;
    bit lst;
    int w;
    drive();
    #1;
    er = '0;
    if (m_busy && !fifo_full_in) er[m_owner] = 1'b1;
    ev = m_busy && !fifo_full_in && vld[m_owner];
    chk("ready", 64'(req_ready_out), 64'(er));
    chk("fvalid", 64'(fifo_valid_out), 64'(ev));
    if (ev)
      chk("fdata", 64'(fifo_data_out),
          64'(mem[m_owner][hd[m_owner]].d));
    chk("busy", 64'(busy_out), 64'(m_busy));
    if (m_busy)
      chk("grant", 64'(grant_out), 64'(m_owner));
    chk("pkt", 64'(pkt_count_out), 64'(m_pkt));
    chk("ovr", 64'(overrun_err_out), 64'(m_ovr));
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        w = (m_ptr + k) % N;
        if (vld[w]) begin
          m_owner = w;
          m_busy  = 1'b1;
          m_beats = 0;
          order.push_back(w);
          break;
        end
      end
    end else if (ev) begin
      wr_cnt[m_owner]++;
      m_beats++;
      lst = mem[m_owner][hd[m_owner]].l;
      hd[m_owner]++;
      if (lst) begin
        m_pkt  = (m_pkt + 1) % 65536;
        m_ptr  = m_owner;
        m_busy = 1'b0;
      end else if (m_beats == MB) begin
        m_ovr  = 1'b1;
        m_ptr  = m_owner;
        m_busy = 1'b0;
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic run_drain(int maxc);
    int n = 0;
    while ((!all_empty() || m_busy) && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 64'(n < maxc), 64'd1);
  endtask

  task automatic do_reset();
    rst_n_in     = 1'b0;
    fifo_full_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      hd[i]     = 0;
      tl[i]     = 0;
      en[i]     = 1'b1;
      wr_cnt[i] = 0;
    end
    drive();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = N - 1;
    m_beats = 0;
    m_pkt   = 0;
    m_ovr   = 1'b0;
    order.delete();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int ovr_ord [3] = '{2, 3, 2};

    tbl[0] = '{4'b0001, 4'b0000, 1'b0, 16'hA0A0,
               4'b0000, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{4'b0001, 4'b0000, 1'b0, 16'hA0A0,
               4'b0001, 1'b1, 1'b1, 0, 0};
    tbl[2] = '{4'b0001, 4'b0000, 1'b0, 16'hB0B0,
               4'b0001, 1'b1, 1'b1, 0, 0};
    tbl[3] = '{4'b0001, 4'b0001, 1'b0, 16'hC0C0,
               4'b0001, 1'b1, 1'b1, 0, 0};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 16'h0000,
               4'b0000, 1'b0, 1'b0, 0, 1};
    tbl[5] = '{4'b0010, 4'b0000, 1'b0, 16'hD0D0,
               4'b0000, 1'b0, 1'b0, 0, 1};
    tbl[6] = '{4'b0010, 4'b0000, 1'b1, 16'hD0D0,
               4'b0000, 1'b0, 1'b1, 1, 1};
    tbl[7] = '{4'b0010, 4'b0000, 1'b0, 16'hD0D0,
               4'b0010, 1'b1, 1'b1, 1, 1};
    tbl[8] = '{4'b0010, 4'b0010, 1'b0, 16'hE0E0,
               4'b0010, 1'b1, 1'b1, 1, 1};
    tbl[9] = '{4'b0000, 4'b0000, 1'b0, 16'h0000,
               4'b0000, 1'b0, 1'b0, 0, 2};

    // reset state
    do_reset();
    #1;
    chk("rst_ready", 64'(req_ready_out), 64'd0);
    chk("rst_fvalid", 64'(fifo_valid_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_grant", 64'(grant_out), 64'd0);
    chk("rst_pkt", 64'(pkt_count_out), 64'd0);
    chk("rst_ovr", 64'(overrun_err_out), 64'd0);
    @(negedge clk_in);

    // vector table: req0 3-beat packet, req1 with full stall
    for (int t = 0; t < 10; t++) begin
      req_valid_in = tbl[t].v;
      req_last_in  = tbl[t].l;
      fifo_full_in = tbl[t].f;
      req_data_in  = {N{tbl[t].d}};
      #1;
      chk("tv_ready", 64'(req_ready_out), 64'(tbl[t].er));
      chk("tv_fvalid", 64'(fifo_valid_out), 64'(tbl[t].ev));
      if (tbl[t].ev)
        chk("tv_fdata", 64'(fifo_data_out), 64'(tbl[t].d));
      chk("tv_busy", 64'(busy_out), 64'(tbl[t].eb));
      if (tbl[t].eb)
        chk("tv_grant", 64'(grant_out), 64'(tbl[t].eg));
      chk("tv_pkt", 64'(pkt_count_out), 64'(tbl[t].ep));
      @(posedge clk_in);
      @(negedge clk_in);
    end

    // all four requesters contend: order 0,1,2,3,0
    do_reset();
    push(0, 16'h0011, 1'b0); push(0, 16'h0012, 1'b1);
    push(0, 16'h0013, 1'b0); push(0, 16'h0014, 1'b1);
    push(1, 16'h0021, 1'b0); push(1, 16'h0022, 1'b1);
    push(2, 16'h0031, 1'b0); push(2, 16'h0032, 1'b1);
    push(3, 16'h0041, 1'b0); push(3, 16'h0042, 1'b1);
    run_drain(60);
    chk("rr_len", 64'(order.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < order.size())
        chk("rr_order", 64'(order[k]), 64'(exp_ord[k]));
    chk("rr_pkt", 64'(pkt_count_out), 64'd5);

    // fifo full for 5 cycles mid-packet on req1
    do_reset();
    push(1, 16'h0101, 1'b0); push(1, 16'h0102, 1'b0);
    push(1, 16'h0103, 1'b0); push(1, 16'h0104, 1'b1);
    repeat (3) cyc();
    fifo_full_in = 1'b1;
    repeat (5) cyc();
    fifo_full_in = 1'b0;
    run_drain(20);
    chk("full_beats", 64'(wr_cnt[1]), 64'd4);
    chk("full_pkt", 64'(pkt_count_out), 64'd1);

    // overrun: req2 sends 6 beats without last
    do_reset();
    for (int b = 0; b < 6; b++)
      push(2, 16'(16'h0200 + b), 1'b0);
    push(3, 16'h0301, 1'b1);
    repeat (14) cyc();
    chk("ovr_flag", 64'(overrun_err_out), 64'd1);
    chk("ovr_pkt", 64'(pkt_count_out), 64'd1);
    chk("ovr_beats", 64'(wr_cnt[2]), 64'd6);
    chk("ovr_len", 64'(order.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (k < order.size())
        chk("ovr_order", 64'(order[k]), 64'(ovr_ord[k]));
    cyc();
    chk("ovr_sticky", 64'(overrun_err_out), 64'd1);

    // async reset mid-packet
    do_reset();
    push(0, 16'h0601, 1'b1);
    push(0, 16'h0602, 1'b0);
    push(0, 16'h0603, 1'b0);
    push(0, 16'h0604, 1'b1);
    repeat (4) cyc();
    drive();
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("arst_ready", 64'(req_ready_out), 64'd0);
    chk("arst_fvalid", 64'(fifo_valid_out), 64'd0);
    chk("arst_busy", 64'(busy_out), 64'd0);
    chk("arst_pkt", 64'(pkt_count_out), 64'd0);
    chk("arst_ovr", 64'(overrun_err_out), 64'd0);
    @(negedge clk_in);
    do_reset();
    push(1, 16'h0711, 1'b1);
    push(0, 16'h0701, 1'b1);
    run_drain(20);
    chk("arst_first", 64'(order.size() > 0 ? order[0] : -1),
        64'd0);
    chk("arst_pkts", 64'(pkt_count_out), 64'd2);

    // packet counter wrap
    do_reset();
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    m_pkt = 16'hFFFE;
    chk("wrap_preload", 64'(pkt_count_out), 64'hFFFE);
    for (int b = 0; b < 3; b++)
      push(0, 16'(16'h0800 + b), 1'b1);
    run_drain(20);
    chk("wrap_pkt", 64'(pkt_count_out), 64'h0001);
    chk("wrap_ovr", 64'(overrun_err_out), 64'd0);

    // randomized traffic
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (hd[i] == tl[i] && $urandom_range(0, 3) == 0) begin
          len = int'($urandom_range(1, MB + 1));
          for (int b = 0; b < len; b++)
            push(i, 16'($urandom), b == len - 1);
        end
        en[i] = ($urandom_range(0, 9) != 0);
      end
      fifo_full_in = ($urandom_range(0, 4) == 0);
      cyc();
    end
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    fifo_full_in = 1'b0;
    run_drain(200);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
